// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM (mc_ctrl_fsm_v2):
// opcode constants, state encodings, instruction classes and the datapath
// mux/ALU control codes driven by the FSM.
package mc_ctrl_pkg;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // FSM states. Encodings 10..14 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JAL       = 4'd9,
        S_TRAP      = 4'd15
    } state_t;

    // Instruction classes produced by mc_opcode_class
    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_RTYPE  = 3'd1,
        CL_ITYPE  = 3'd2,
        CL_LOAD   = 3'd3,
        CL_STORE  = 3'd4,
        CL_BRANCH = 3'd5,
        CL_JAL    = 3'd6
    } iclass_t;

    // ALUOp codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RFUNC = 2'b10;
    localparam logic [1:0] ALU_IFUNC = 2'b11;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // PCSource codes
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;

    // MemtoReg codes
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode/funct3 classifier.
// Ports:
//   i_opcode  in  7  instr[6:0]
//   i_funct3  in  3  instr[14:12]
//   o_class   out    instruction class (iclass_t), CL_NONE when illegal
//   o_legal   out 1  1 = supported instruction
module mc_opcode_class
    import mc_ctrl_pkg::*;
#(
    parameter int HAS_JAL = 1
) (
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output iclass_t    o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = CL_NONE;
        o_legal = 1'b1;
        case (i_opcode)
            OP_RTYPE: o_class = CL_RTYPE;
            OP_ITYPE: o_class = CL_ITYPE;
            OP_LOAD:  o_class = CL_LOAD;
            OP_STORE: o_class = CL_STORE;
            OP_BRANCH: begin
                // only beq (000) and bne (001) are supported
                if (i_funct3[2:1] == 2'b00) o_class = CL_BRANCH;
                else                        o_legal = 1'b0;
            end
            OP_JAL: begin
                if (HAS_JAL != 0) o_class = CL_JAL;
                else              o_legal = 1'b0;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm_v2.sv
// Multicycle RISC-V control FSM with memory wait states and illegal-opcode
// handling. Drives the datapath mux selects and write enables.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   opcode, funct3        fields from the instruction register
//   mem_ready             memory access completes this cycle
//   MemRead/MemWrite/IorD memory strobes and address select
//   IRWrite/PCWrite/PCWriteCond/branch_ne/PCSource   fetch/PC control
//   ALUSrcA/ALUSrcB/ALUOp ALU operand/op control
//   RegWrite/MemtoReg     register file write control
//   illegal               illegal-opcode flag
//   state_o               current state (debug)
module mc_ctrl_fsm_v2
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT  = 1,
    parameter int HAS_JAL   = 1,
    parameter int TRAP_HALT = 1,
    parameter int STATE_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               mem_ready,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               branch_ne,
    output logic [1:0]         PCSource,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               RegWrite,
    output logic [1:0]         MemtoReg,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_t  r_state;
    state_t  w_next;
    logic    r_ill_pend;    // illegal pulse owed to the following FETCH cycle
    logic    w_ill_set;
    logic    w_rdy;
    iclass_t w_class;
    logic    w_legal;

    assign w_rdy = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

    mc_opcode_class #(.HAS_JAL(HAS_JAL)) u_class (
        .i_opcode (opcode),
        .i_funct3 (funct3),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    // Skip mode only: remember the illegal decode so FETCH can flag it once
    assign w_ill_set = (r_state == S_DECODE) && !w_legal && (TRAP_HALT == 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_ill_pend <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ill_pend <= w_ill_set;
        end
    end

    assign state_o = STATE_W'(r_state);

    always_comb begin
        w_next      = r_state;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        branch_ne   = 1'b0;
        PCSource    = PCS_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        RegWrite    = 1'b0;
        MemtoReg    = M2R_ALUOUT;
        illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_4;
                // IR load and PC+4 commit only on the completing cycle
                IRWrite = w_rdy;
                PCWrite = w_rdy;
                illegal = r_ill_pend;
                if (w_rdy) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM;     // branch/jal target into ALUOut
                if (!w_legal) begin
                    w_next = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
                end else begin
                    case (w_class)
                        CL_LOAD, CL_STORE: w_next = S_MEM_ADDR;
                        CL_RTYPE, CL_ITYPE: w_next = S_EXEC;
                        CL_BRANCH:         w_next = S_BRANCH;
                        CL_JAL:            w_next = S_JAL;
                        default:           w_next = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (w_class)
                    CL_LOAD:  w_next = S_MEM_READ;
                    CL_STORE: w_next = S_MEM_WRITE;
                    default:  w_next = S_FETCH;
                endcase
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (w_rdy) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_MDR;
                w_next   = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (w_rdy) w_next = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (w_class == CL_RTYPE) begin
                    ALUSrcB = SRCB_REG;
                    ALUOp   = ALU_RFUNC;
                end else begin
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_IFUNC;
                end
                w_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_ALUOUT;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCS_ALUOUT;
                branch_ne   = funct3[0];
                w_next      = S_FETCH;
            end
            S_JAL: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_PC;
                PCWrite  = 1'b1;
                PCSource = PCS_ALUOUT;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;         // halted until reset
            end
            default: w_next = S_FETCH;
        endcase

        // Reset overrides everything combinationally, so a pending store
        // strobe drops in the same cycle reset rises.
        if (reset) begin
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IorD        = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            branch_ne   = 1'b0;
            PCSource    = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            RegWrite    = 1'b0;
            MemtoReg    = 2'b00;
            illegal     = 1'b0;
        end
    end

endmodule

// File: doc/mc_ctrl_fsm_v2.md
Name: mc_ctrl_fsm_v2

Overview:
- Parametrised successor to the multicycle RISC-V control FSM.
- Adds the R-type, I-type ALU, lw, sw, beq/bne and jal instruction classes.
- Adds a memory wait-state handshake (mem_ready) and illegal-opcode detection with a trap/skip mode.
- Sits between the instruction register (opcode/funct3) and the multicycle datapath muxes and write enables.

Parameters:
- MEM_WAIT, 1, 1: FETCH/MEM_READ/MEM_WRITE hold until mem_ready=1; 0: mem_ready ignored (treated as 1).
- HAS_JAL, 1, 1: jal (1101111) decoded; 0: jal is illegal.
- TRAP_HALT, 1, 1: illegal opcode enters TRAP and halts until reset; 0: pulse illegal for one cycle, then FETCH.
- STATE_W, 4, width of state_o (minimum 4).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12] from IR
- mem_ready  in  1  memory access completes this cycle
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRWrite  out  1  IR load enable
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write if branch condition true
- branch_ne  out  1  0 = take on zero (beq), 1 = take on not-zero (bne)
- PCSource  out  2  00 ALU result, 01 ALUOut, 10/11 reserved
- ALUSrcA  out  1  0 = old PC, 1 = reg A
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 immediate
- ALUOp  out  2  00 add, 01 sub, 10 R-funct, 11 I-funct
- RegWrite  out  1  register file write
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- illegal  out  1  illegal-opcode flag
- state_o  out  STATE_W  current state encoding, for debug

Behaviour:
- Reset: asynchronous and active-high. While reset=1, state=FETCH and all outputs are forced to 0.
- First FETCH cycle is the first rising edge after reset deasserts.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, ALU_WB=7, BRANCH=8, JAL=9, TRAP=15.
- Outputs are Moore-decoded from state, except the mem_ready-gated strobes noted below. Unlisted outputs are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready, so the PC increments exactly once per fetch.
  - Next state: DECODE if mem_ready, else stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch/jal target into ALUOut).
  - Next state by opcode: 0000011/0100011 -> MEM_ADDR; 0110011/0010011 -> EXEC; 1100011 with funct3 000/001 -> BRANCH; 1101111 with HAS_JAL=1 -> JAL.
  - Any other opcode/funct3 combination is illegal.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw -> MEM_READ, sw -> MEM_WRITE. Opcode is sampled from the IR, which is stable.
- MEM_READ: MemRead=1, IorD=1. Next state: MEM_WB on mem_ready.
- MEM_WB: RegWrite=1, MemtoReg=01. Next state: FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Next state: FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB = 00 for R-type / 10 for I-type, ALUOp = 10 for R-type / 11 for I-type. Next state: ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=00. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, branch_ne=funct3[0]. Next state: FETCH.
- JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01. Next state: FETCH.
- TRAP: illegal=1 and all write strobes 0. Stays in TRAP until reset.
- Illegal opcode in DECODE:
  - TRAP_HALT=1: go to TRAP.
  - TRAP_HALT=0: illegal=1 for the next single cycle (in FETCH), then continue normally.
- Latency with zero wait states: R/I 4 cycles, lw 5, sw 4, branch 3, jal 3. Each wait cycle adds 1.
- Reset mid-instruction: state is immediately forced to FETCH with outputs 0. A pending MemWrite is dropped in the same cycle.
- Unused state encodings recover to FETCH on the next edge.

Decomposition:
- Shared package mc_ctrl_pkg:
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL
  - state encodings
  - ALUOp, ALUSrcB, PCSource and MemtoReg codes
- One natural sub-module, mc_opcode_class: combinational opcode/funct3 -> {class, legal}, used by DECODE and MEM_ADDR.

Test Plan:
- Reset high for 2 cycles, then release, mem_ready=1 -> FETCH shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01; next cycle DECODE shows ALUSrcB=10, ALUOp=00.
- opcode=0000011, mem_ready low for 2 cycles in MEM_READ -> state sequence 0,1,2,3,3,3,4,0; RegWrite=1 and MemtoReg=01 only in state 4.
- opcode=1100011, funct3=001 -> BRANCH shows PCWriteCond=1, branch_ne=1, ALUOp=01, PCSource=01; back to FETCH after 3 cycles total.
- opcode=1101111, HAS_JAL=1 -> JAL shows PCWrite=1, RegWrite=1, MemtoReg=10; with HAS_JAL=0 the same opcode -> TRAP, illegal=1, held for 10 cycles until reset.
- opcode=1100111 (jalr, unsupported) with TRAP_HALT=0 -> illegal pulses for exactly 1 cycle, then normal fetch resumes.
- Assert reset during MEM_WRITE while mem_ready=0 -> MemWrite drops to 0 in the same cycle; FETCH follows release.
